// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: owns the register file and PSR, feeds an external
// combinational ALU, captures its result and writes it back.
module alu_exec_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int FLAG_W = 5,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr_op,
  input  logic [AW-1:0]     instr_rdest,
  input  logic [AW-1:0]     instr_rsrc,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_use_imm,
  input  logic              instr_wb,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags_q,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  // state | meaning
  // IDLE  | ready for an instruction; captures it on handshake
  // READ  | registers ALU operands from the register file / immediate
  // EXEC  | ALU settles; C and Flags captured at the end of the cycle
  // WB    | writes C back (if requested), updates PSR, pulses done
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t              state;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [7:0]          op_q;
  logic [AW-1:0]       rdest_q;
  logic [AW-1:0]       rsrc_q;
  logic [DATA_W-1:0]   imm_q;
  logic                use_imm_q;
  logic                wb_q;
  logic [DATA_W-1:0]   c_q;
  logic [FLAG_W-1:0]   flags_tmp;

  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      result      <= '0;
      flags_q     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      op_q        <= '0;
      rdest_q     <= '0;
      rsrc_q      <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      wb_q        <= 1'b0;
      c_q         <= '0;
      flags_tmp   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q        <= instr_op;
            rdest_q     <= instr_rdest;
            rsrc_q      <= instr_rsrc;
            imm_q       <= instr_imm;
            use_imm_q   <= instr_use_imm;
            wb_q        <= instr_wb;
            instr_ready <= 1'b0;
            state       <= READ;
          end
        end
        READ: begin
          alu_a      <= regs[rdest_q];
          alu_b      <= use_imm_q ? imm_q : regs[rsrc_q];
          alu_opcode <= op_q;
          state      <= EXEC;
        end
        EXEC: begin
          c_q       <= alu_c;
          flags_tmp <= alu_flags;
          state     <= WB;
        end
        WB: begin
          if (wb_q) regs[rdest_q] <= c_q;
          flags_q     <= flags_tmp;
          result      <= c_q;
          done        <= 1'b1;
          // back in IDLE next cycle, so a held-high valid is taken alongside done
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
